// File: rtl/systolic_feed_ram.sv
// Multi-bank operand memory for the systolic array: N banks sharing one write port,
// streamed in parallel with lane i skewed by i cycles to form the PE diagonal wavefront.
module systolic_feed_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int N      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] wr_ch,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          start,
    input  logic [ADDR_W-1:0]             base,
    input  logic [ADDR_W:0]               len,
    output logic                          busy,
    output logic                          done,
    output logic [N*DATA_W-1:0]           dout,
    output logic [N-1:0]                  dout_valid
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CH_W  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     cnt;
    logic                zero_done;
    logic [N-1:0]        vld;
    logic [N-1:0]        lst;
    logic                streaming;
    logic                issue_last;
    logic [ADDR_W-1:0]   raddr;

    assign streaming  = (state == STREAM);
    assign issue_last = streaming && (cnt == len_q - 1'b1);
    assign raddr      = base_q + cnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            zero_done <= 1'b0;
            base_q    <= '0;
            len_q     <= '0;
            cnt       <= '0;
        end else begin
            zero_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            base_q <= base;
                            len_q  <= len;
                            cnt    <= '0;
                            busy   <= 1'b1;
                            state  <= STREAM;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    cnt <= cnt + 1'b1;
                    if (issue_last) state <= DRAIN;
                end
                DRAIN: begin
                    // The last lane's final word is on the bus this cycle.
                    if (lst[N-1]) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Valid and last-word markers ride a shared skew chain; stage i belongs to lane i.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            lst <= '0;
        end else begin
            vld[0] <= streaming;
            lst[0] <= issue_last;
            for (int j = 1; j < N; j++) begin
                vld[j] <= vld[j-1];
                lst[j] <= lst[j-1];
            end
        end
    end

    assign done       = lst[N-1] | zero_done;
    assign dout_valid = vld;

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [DATA_W-1:0] sr  [gi+1];

        // NOTE: bank storage has no reset; clearing a RAM array would defeat RAM inference.
        always_ff @(posedge clk) begin
            if (wr_en && (wr_ch == CH_W'(gi))) mem[wr_addr] <= wr_data;
        end

        // NOTE: non-blocking assignment makes a same-cycle write invisible to this read,
        // giving read-before-write behaviour without any bypass logic.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= gi; j++) sr[j] <= '0;
            end else begin
                sr[0] <= streaming ? mem[raddr] : '0;
                for (int j = 1; j <= gi; j++) sr[j] <= sr[j-1];
            end
        end

        assign dout[gi*DATA_W +: DATA_W] = sr[gi];
    end

endmodule

// File: tb/tb_systolic_feed_ram.sv
// Scoreboard bench for systolic_feed_ram: stream expectations are queued at start time
// from a bank model and retired cycle by cycle against the lane outputs.
module tb_systolic_feed_ram;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int N     = 2;
    localparam int DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [0:0]        wr_ch;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              start;
    logic [AW-1:0]     base;
    logic [AW:0]       len;
    logic              busy;
    logic              done;
    logic [N*DW-1:0]   dout;
    logic [N-1:0]      dout_valid;

    systolic_feed_ram #(.DATA_W(DW), .ADDR_W(AW), .N(N)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .base(base), .len(len), .busy(busy),
        .done(done), .dout(dout), .dout_valid(dout_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
    typedef struct { int lo; int hi; } win_t;

    exp_t          lane_q [N][$];
    int            done_q [$];
    win_t          busy_q [$];
    logic [DW-1:0] model  [N][DEPTH];

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    bit mon_en    = 0;

    // Scoreboard consumer: every cycle each lane, done and busy are set against the queues.
    always @(negedge clk) begin
        logic          ev;
        logic [DW-1:0] ed;
        logic          edone;
        logic          ebusy;
        if (mon_en) begin
            for (int i = 0; i < N; i++) begin
                ev = 1'b0;
                ed = '0;
                if (lane_q[i].size() > 0 && lane_q[i][0].cyc == cyc) begin
                    ev = 1'b1;
                    ed = lane_q[i][0].data;
                    void'(lane_q[i].pop_front());
                end
                checks++;
                if (dout_valid[i] !== ev || dout[i*DW +: DW] !== ed) begin
                    errors++;
                    $display("FAIL lane%0d cycle %0d: got valid=%b data=%h, want valid=%b data=%h",
                             i, cyc, dout_valid[i], dout[i*DW +: DW], ev, ed);
                end
            end
            edone = 1'b0;
            if (done_q.size() > 0 && done_q[0] == cyc) begin
                edone = 1'b1;
                void'(done_q.pop_front());
            end
            checks++;
            if (done !== edone) begin
                errors++;
                $display("FAIL done cycle %0d: got %b, want %b", cyc, done, edone);
            end
            if (done === 1'b1) done_seen++;
            ebusy = 1'b0;
            if (busy_q.size() > 0 && busy_q[0].lo <= cyc && cyc <= busy_q[0].hi) ebusy = 1'b1;
            if (busy_q.size() > 0 && busy_q[0].hi == cyc) void'(busy_q.pop_front());
            checks++;
            if (busy !== ebusy) begin
                errors++;
                $display("FAIL busy cycle %0d: got %b, want %b", cyc, busy, ebusy);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit pending();
        int n;
        n = done_q.size() + busy_q.size();
        for (int i = 0; i < N; i++) n += lane_q[i].size();
        return n != 0;
    endfunction

    task automatic flush();
        for (int i = 0; i < N; i++) lane_q[i].delete();
        done_q.delete();
        busy_q.delete();
    endtask

    task automatic write_word(input logic [0:0] ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_addr = a;
        wr_data = d;
        if (int'(ch) < N) model[ch][a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_stream(input int t, input int b, input int l);
        for (int k = 0; k < l; k++)
            for (int i = 0; i < N; i++)
                lane_q[i].push_back('{t + 2 + k + i, model[i][(b + k) % DEPTH]});
        if (l == 0) begin
            done_q.push_back(t + 1);
        end else begin
            done_q.push_back(t + l + N);
            busy_q.push_back('{t + 1, t + l + N});
        end
    endtask

    task automatic run_stream(input int b, input int l);
        base  = AW'(b);
        len   = (AW+1)'(l);
        start = 1'b1;
        push_stream(cyc, b, l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while (pending() && n < max_cycles) begin
            tick();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL drain_timeout cycle %0d: expectations still queued after %0d cycles", cyc, max_cycles);
            flush();
        end
    endtask

    task automatic preload();
        write_word(1'b0, 4'd0, 16'd9);
        write_word(1'b0, 4'd1, 16'd1);
        write_word(1'b0, 4'd2, 16'd1);
        write_word(1'b0, 4'd3, 16'd9);
        write_word(1'b1, 4'd0, 16'd8);
        write_word(1'b1, 4'd1, 16'd4);
        write_word(1'b1, 4'd2, 16'd1);
        write_word(1'b1, 4'd3, 16'd1);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base = '0; len = '0;
        for (int i = 0; i < N; i++)
            for (int a = 0; a < DEPTH; a++) model[i][a] = '0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
        checks++;
        if (dout_valid !== '0) begin errors++; $display("FAIL reset_valid: got %b, want 0", dout_valid); end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL reset_dout: got %h, want 0", dout); end
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        preload();
        run_stream(0, 4);
        wait_idle(40);
    endtask

    task automatic test_wrap();
        write_word(1'b0, 4'd14, 16'd5);
        write_word(1'b0, 4'd15, 16'd6);
        write_word(1'b0, 4'd0,  16'd7);
        write_word(1'b0, 4'd1,  16'd8);
        write_word(1'b1, 4'd14, 16'h0303);
        write_word(1'b1, 4'd15, 16'h0202);
        run_stream(14, 4);
        wait_idle(40);
    endtask

    task automatic test_len0_and_ignore();
        int d0;
        d0 = done_seen;
        run_stream(3, 0);
        wait_idle(10);
        repeat (3) tick();
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL len0_done_count: got %0d pulses, want 1", done_seen - d0);
        end
        d0 = done_seen;
        run_stream(0, 4);
        tick();
        base  = 4'd5;
        len   = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(40);
        repeat (4) tick();
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL busy_start_ignored: got %0d done pulses, want 1", done_seen - d0);
        end
    endtask

    task automatic test_rw_collision();
        int t;
        t = cyc;
        run_stream(0, 4);
        tick();
        tick();
        if (cyc != t + 3) begin
            checks++; errors++;
            $display("FAIL collision_align: cycle %0d, want %0d", cyc, t + 3);
        end
        write_word(1'b0, 4'd2, 16'hABCD);
        wait_idle(40);
        run_stream(0, 4);
        wait_idle(40);
    endtask

    task automatic test_mid_reset();
        int d0;
        preload();
        run_stream(0, 4);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        flush();
        d0 = done_seen;
        repeat (8) tick();
        checks++;
        if (done_seen != d0) begin
            errors++;
            $display("FAIL mid_reset_no_done: got %0d pulses, want 0", done_seen - d0);
        end
        run_stream(0, 4);
        wait_idle(40);
    endtask

    task automatic test_back_to_back();
        int t1, t2, n;
        int firsts[$];
        bit prev;
        base  = 4'd0;
        len   = 5'd4;
        start = 1'b1;
        t1 = cyc;
        t2 = t1 + 4 + N + 1;
        push_stream(t1, 0, 4);
        push_stream(t2, 0, 4);
        prev = 1'b0;
        n = 0;
        while (pending() && n < 60) begin
            tick();
            n++;
            if (cyc == t2 + 1) start = 1'b0;
            if (dout_valid[0] && !prev) firsts.push_back(cyc);
            prev = dout_valid[0];
        end
        start = 1'b0;
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL b2b_timeout: expectations still queued at cycle %0d", cyc);
            flush();
        end
        checks++;
        if (firsts.size() != 2) begin
            errors++;
            $display("FAIL b2b_bursts: got %0d lane0 bursts, want 2", firsts.size());
        end else begin
            checks++;
            if (firsts[1] - firsts[0] != 4 + N + 1) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d cycles, want %0d", firsts[1] - firsts[0], 4 + N + 1);
            end
        end
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_len0_and_ignore();
        test_rw_collision();
        test_mid_reset();
        test_back_to_back();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
